// File: rtl/spiram_master_if.sv
// Native word-wide memory bus between the CPU and spiram_master.
interface spiram_master_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        busy;

    modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_ready, mem_rdata, busy);
    modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    output mem_ready, mem_rdata, busy);
endinterface

// File: rtl/spiram_master.sv
// SPI mode-0 master mapping word reads/writes onto serial SPI RAM 0x03/0x02 commands.
module spiram_master #(
    parameter int CLK_DIV  = 1,
    parameter int CSB_IDLE = 2
) (
    input  logic           clk,
    input  logic           resetn,
    spiram_master_if.slave bus,
    output logic           spi_csb,
    output logic           spi_clk,
    output logic           spi_io0,
    input  logic           spi_io1
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t state, state_d;

    logic [7:0]  div_cnt, hi_cnt;
    logic [5:0]  bit_cnt;
    logic [63:0] tx, frame_d;
    logic [31:0] rx;
    logic [21:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  lanes_q, lane_low, lanes_left;
    logic        read_q, short_q;
    logic        div_end, last_bit, hi_ok;
    logic        accept, restart, rise, fall, hold_end;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^bus.mem_addr[1:0];

    // Frame left-aligned in 64 bits; partial writes carry one byte for the lowest pending lane.
    function automatic logic [63:0] frame(input logic [21:0] aw, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [1:0] lane;
        logic [7:0] b;
        if (s == 4'h0)
            return {8'h03, aw, 2'b00, 32'h0};
        if (s == 4'hF)
            return {8'h02, aw, 2'b00, d[7:0], d[15:8], d[23:16], d[31:24]};
        if (s[0])      begin lane = 2'd0; b = d[7:0];   end
        else if (s[1]) begin lane = 2'd1; b = d[15:8];  end
        else if (s[2]) begin lane = 2'd2; b = d[23:16]; end
        else           begin lane = 2'd3; b = d[31:24]; end
        return {8'h02, aw, lane, b, 24'h0};
    endfunction

    assign frame_d    = (state == IDLE) ? frame(bus.mem_addr[23:2], bus.mem_wdata, bus.mem_wstrb)
                                        : frame(addr_q, wdata_q, lanes_q);
    assign lane_low   = lanes_q & (~lanes_q + 4'd1);
    assign lanes_left = lanes_q & ~lane_low;
    assign div_end    = div_cnt == 8'(CLK_DIV - 1);
    assign last_bit   = bit_cnt == (short_q ? 6'd39 : 6'd63);
    assign hi_ok      = hi_cnt >= 8'(CSB_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d  = state;
        accept   = 1'b0;
        restart  = 1'b0;
        rise     = 1'b0;
        fall     = 1'b0;
        hold_end = 1'b0;
        unique case (state)
            IDLE:  if (bus.mem_valid && hi_ok) begin accept = 1'b1; state_d = SETUP; end
            SETUP: if (div_end) begin rise = 1'b1; state_d = SHIFT; end
            SHIFT: if (div_end) begin
                       if (spi_clk)       fall = 1'b1;
                       else if (last_bit) state_d = HOLD;
                       else               rise = 1'b1;
                   end
            HOLD:  if (div_end) begin hold_end = 1'b1; state_d = GAP; end
            GAP:   if (lanes_q == 4'h0) state_d = IDLE;
                   else if (hi_ok) begin restart = 1'b1; state_d = SETUP; end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            spi_csb       <= 1'b1;
            spi_clk       <= 1'b0;
            spi_io0       <= 1'b0;
            bus.mem_ready <= 1'b0;
            bus.busy      <= 1'b0;
            bus.mem_rdata <= '0;
            div_cnt       <= '0;
            hi_cnt        <= 8'(CSB_IDLE);
            bit_cnt       <= '0;
            tx            <= '0;
            rx            <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            lanes_q       <= '0;
            read_q        <= 1'b0;
            short_q       <= 1'b0;
        end else begin
            bus.mem_ready <= 1'b0;
            div_cnt <= (state_d != state || div_end) ? 8'd0 : div_cnt + 8'd1;
            if (accept) begin
                addr_q   <= bus.mem_addr[23:2];
                wdata_q  <= bus.mem_wdata;
                read_q   <= bus.mem_wstrb == 4'h0;
                short_q  <= bus.mem_wstrb != 4'h0 && bus.mem_wstrb != 4'hF;
                lanes_q  <= (bus.mem_wstrb != 4'hF) ? bus.mem_wstrb : 4'h0;
                bus.busy <= 1'b1;
            end
            if (accept || restart) begin
                tx      <= frame_d;
                spi_io0 <= frame_d[63];
                spi_csb <= 1'b0;
            end
            if (rise) begin
                spi_clk <= 1'b1;
                rx      <= {rx[30:0], spi_io1};
                bit_cnt <= (state == SETUP) ? 6'd0 : bit_cnt + 6'd1;
            end
            if (fall) begin
                spi_clk <= 1'b0;
                tx      <= {tx[62:0], 1'b0};
                spi_io0 <= tx[62];
            end
            if (hold_end) begin
                spi_csb <= 1'b1;
                lanes_q <= lanes_left;
                if (lanes_left == 4'h0) begin
                    bus.mem_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    // First received byte lands in the low lane.
                    if (read_q) bus.mem_rdata <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
                end
            end
            if (accept || restart)            hi_cnt <= 8'd0;
            else if (hold_end)                hi_cnt <= 8'd1;
            else if (spi_csb && hi_cnt != 8'hFF) hi_cnt <= hi_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_spiram_master.sv
// Directed bench: two masters (CLK_DIV=1/CSB_IDLE=2 and 3/4) share one behavioural SPI RAM.
module tb_spiram_master;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [23:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;

    spiram_master_if b1();
    spiram_master_if b3();
    assign b1.mem_valid = req_valid & ~sel;
    assign b3.mem_valid = req_valid & sel;
    assign b1.mem_addr  = req_addr;
    assign b3.mem_addr  = req_addr;
    assign b1.mem_wdata = req_wdata;
    assign b3.mem_wdata = req_wdata;
    assign b1.mem_wstrb = req_wstrb;
    assign b3.mem_wstrb = req_wstrb;

    wire        ready = sel ? b3.mem_ready : b1.mem_ready;
    wire [31:0] rdata = sel ? b3.mem_rdata : b1.mem_rdata;
    wire        busy  = sel ? b3.busy      : b1.busy;

    logic c1, k1, o1, c3, k3, o3;
    logic miso = 1'b0;
    wire  m_csb  = sel ? c3 : c1;
    wire  m_sclk = sel ? k3 : k1;
    wire  m_mosi = sel ? o3 : o1;

    spiram_master #(.CLK_DIV(1), .CSB_IDLE(2)) dut1 (
        .clk(clk), .resetn(resetn), .bus(b1),
        .spi_csb(c1), .spi_clk(k1), .spi_io0(o1), .spi_io1(miso));
    spiram_master #(.CLK_DIV(3), .CSB_IDLE(4)) dut3 (
        .clk(clk), .resetn(resetn), .bus(b3),
        .spi_csb(c3), .spi_clk(k3), .spi_io0(o3), .spi_io1(miso));

    // Behavioural SPI RAM, mode 0.
    logic [7:0]  mem [0:4095];
    int          bits = 0;
    int          idx, k;
    logic [7:0]  sh, cmd, rb;
    logic [23:0] adr;
    logic [7:0]  mosi_q[$];
    logic [23:0] win_addr[$];
    int          low_len[$];
    int          high_len[$];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) mem[12'h200 + i] = 8'hAA;
        for (int i = 0; i < 8; i++) mem[12'h400 + i] = 8'(i + 1);
    end

    always @(negedge m_csb) begin
        bits = 0; cmd = 8'h00; adr = '0;
    end

    always @(posedge m_sclk) if (!m_csb) begin
        sh = {sh[6:0], m_mosi};
        bits++;
        if (bits % 8 == 0) begin
            idx = bits / 8 - 1;
            mosi_q.push_back(sh);
            if (idx == 0) cmd = sh;
            else if (idx <= 3) begin
                adr = {adr[15:0], sh};
                if (idx == 3) win_addr.push_back(adr);
            end else if (cmd == 8'h02) mem[adr[11:0] + 12'(idx - 4)] = sh;
        end
    end

    always @(negedge m_sclk) if (!m_csb && cmd == 8'h03 && bits >= 32) begin
        k = bits - 32;
        rb = mem[adr[11:0] + 12'(k / 8)];
        miso = rb[7 - (k % 8)];
    end

    // csb window lengths and spi_clk phase lengths, sampled mid-cycle.
    int lo_run = 0, hi_run = 0, sh_run = 0, sl_run = 0;
    int min_sh = 1000, max_sh = 0, min_sl = 1000, max_sl = 0;
    logic prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (m_csb === 1'b0) begin
            if (hi_run > 0) begin high_len.push_back(hi_run); hi_run = 0; end
            lo_run++;
            if (m_sclk) begin
                if (!prev_sclk && sl_run > 0) begin
                    if (sl_run < min_sl) min_sl = sl_run;
                    if (sl_run > max_sl) max_sl = sl_run;
                end
                sh_run++; sl_run = 0;
            end else begin
                if (prev_sclk) begin
                    if (sh_run < min_sh) min_sh = sh_run;
                    if (sh_run > max_sh) max_sh = sh_run;
                end
                sh_run = 0; sl_run++;
            end
        end else begin
            if (lo_run > 0) begin low_len.push_back(lo_run); lo_run = 0; end
            hi_run++; sh_run = 0; sl_run = 0;
        end
        prev_sclk = m_sclk;
    end

    task automatic clear_log();
        mosi_q.delete(); win_addr.delete(); low_len.delete(); high_len.delete();
        min_sh = 1000; max_sh = 0; min_sl = 1000; max_sl = 0;
    endtask

    function automatic logic [79:0] pack_log(input int n);
        logic [79:0] v = '0;
        for (int i = 0; i < n && i < mosi_q.size(); i++) v = (v << 8) | 80'(mosi_q[i]);
        return v;
    endfunction

    task automatic txn(input bit s, input logic [23:0] a, input logic [31:0] d,
                       input logic [3:0] st, input bit scramble,
                       output logic [31:0] rd, output int lat, output bit busy_ok);
        int t0;
        @(negedge clk);
        sel = s; req_addr = a; req_wdata = d; req_wstrb = st; req_valid = 1'b1;
        t0 = cyc; lat = -1; rd = 'x; busy_ok = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 0 && scramble) begin req_addr = ~a; req_wdata = ~d; end
            if (ready === 1'b1) begin
                lat = cyc - t0; rd = rdata; busy_ok = busy_ok && (busy === 1'b0);
                break;
            end
            busy_ok = busy_ok && (busy === 1'b1);
        end
        req_valid = 1'b0;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL txn_timeout: no mem_ready for addr %h, required within 3000 cycles", a);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({c1, k1, o1, b1.mem_ready, b1.busy, c3, k3, o3, b3.mem_ready, b3.busy}
                !== 10'b1000010000) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %b required 1000010000", i,
                         {c1, k1, o1, b1.mem_ready, b1.busy, c3, k3, o3, b3.mem_ready, b3.busy});
            end
        end
        checks++;
        if ({b1.mem_rdata, b3.mem_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h required 0", b1.mem_rdata, b3.mem_rdata);
        end
    endtask

    task automatic test_full_write();
        logic [31:0] rd; int lat; bit bok;
        clear_log();
        txn(1'b0, 24'h000100, 32'hDEADBEEF, 4'hF, 1'b0, rd, lat, bok);
        checks++;
        if (mosi_q.size() != 8 || pack_log(8) !== 80'h02000100EFBEADDE) begin
            errors++;
            $display("FAIL full_write_mosi: got %0d bytes %h required 02000100EFBEADDE",
                     mosi_q.size(), pack_log(8));
        end
        checks++;
        if (low_len.size() != 1 || low_len[0] != 130) begin
            errors++;
            $display("FAIL full_write_csb_low: got %0d windows first %0d required 1 of 130",
                     low_len.size(), low_len.size() ? low_len[0] : -1);
        end
        checks++;
        if (lat != 131 || !bok) begin
            errors++;
            $display("FAIL full_write_timing: latency %0d busy_ok %0d required 131 and 1", lat, bok);
        end
    endtask

    task automatic test_read();
        logic [31:0] rd; int lat; bit bok;
        repeat (5) @(negedge clk);
        clear_log();
        txn(1'b0, 24'h000100, 32'h0, 4'h0, 1'b0, rd, lat, bok);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL read_data: got %h required deadbeef", rd);
        end
        checks++;
        if (lat != 131 || !bok) begin
            errors++; $display("FAIL read_latency: got %0d busy_ok %0d required 131 and 1", lat, bok);
        end
        checks++;
        if (pack_log(8) !== 80'h0300010000000000) begin
            errors++; $display("FAIL read_mosi: got %h required 0300010000000000", pack_log(8));
        end
    endtask

    task automatic test_partial_write();
        logic [31:0] rd; int lat; bit bok;
        clear_log();
        txn(1'b0, 24'h000200, 32'h11223344, 4'b0101, 1'b0, rd, lat, bok);
        checks++;
        if (win_addr.size() != 2 || low_len.size() != 2) begin
            errors++;
            $display("FAIL partial_windows: got %0d windows required 2", low_len.size());
        end else begin
            checks++;
            if (win_addr[0] !== 24'h000200 || win_addr[1] !== 24'h000202) begin
                errors++;
                $display("FAIL partial_addr: got %h,%h required 000200,000202",
                         win_addr[0], win_addr[1]);
            end
            checks++;
            if (low_len[0] != 82 || low_len[1] != 82 || high_len.size() < 2 || high_len[1] != 2) begin
                errors++;
                $display("FAIL partial_timing: low %0d,%0d gap %0d required 82,82 gap 2",
                         low_len[0], low_len[1], high_len.size() > 1 ? high_len[1] : -1);
            end
        end
        checks++;
        if (pack_log(10) !== 80'h02000200440200020222) begin
            errors++; $display("FAIL partial_mosi: got %h required 02000200440200020222", pack_log(10));
        end
        checks++;
        if (b1.mem_rdata !== 32'hDEADBEEF || !bok) begin
            errors++;
            $display("FAIL partial_rdata_hold: got %h busy_ok %0d required deadbeef and 1",
                     b1.mem_rdata, bok);
        end
        txn(1'b0, 24'h000200, 32'h0, 4'h0, 1'b0, rd, lat, bok);
        checks++;
        if (rd !== 32'hAA22AA44) begin
            errors++; $display("FAIL partial_readback: got %h required aa22aa44", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd1, rd2; int lat1, t0, n;
        clear_log();
        @(negedge clk);
        sel = 1'b1; req_addr = 24'h000400; req_wstrb = 4'h0; req_valid = 1'b1;
        t0 = cyc; lat1 = -1; n = 0; rd1 = 'x; rd2 = 'x;
        for (int i = 0; i < 2000 && n < 2; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                if (n == 0) begin lat1 = cyc - t0; rd1 = rdata; req_addr = 24'h000404; end
                else rd2 = rdata;
                n++;
            end
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b0;
        checks++;
        if (rd1 !== 32'h04030201 || rd2 !== 32'h08070605) begin
            errors++; $display("FAIL b2b_data: got %h,%h required 04030201,08070605", rd1, rd2);
        end
        checks++;
        if (lat1 != 391) begin
            errors++; $display("FAIL b2b_latency: got %0d required 391", lat1);
        end
        checks++;
        if (low_len.size() != 2 || low_len[0] != 390 || low_len[1] != 390) begin
            errors++;
            $display("FAIL b2b_csb_low: got %0d windows first %0d required 2 of 390",
                     low_len.size(), low_len.size() ? low_len[0] : -1);
        end
        checks++;
        if (high_len.size() < 2 || high_len[1] < 4) begin
            errors++;
            $display("FAIL b2b_csb_gap: got %0d required >=4", high_len.size() > 1 ? high_len[1] : -1);
        end
        checks++;
        if (min_sh != 3 || max_sh != 3 || min_sl != 3 || max_sl != 3) begin
            errors++;
            $display("FAIL b2b_sclk_phase: high %0d..%0d low %0d..%0d required 3", min_sh, max_sh,
                     min_sl, max_sl);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; bit bok, hit, saw_ready;
        @(negedge clk);
        sel = 1'b0; req_addr = 24'h000100; req_wstrb = 4'h0; req_valid = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_csb === 1'b0 && bits >= 26) begin hit = 1'b1; break; end
        end
        resetn = 1'b0; req_valid = 1'b0;
        #1;
        checks++;
        if (!hit || c1 !== 1'b1 || b1.mem_ready !== 1'b0 || b1.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_csb: reached %0d csb %b ready %b busy %b required 1,1,0,0",
                     hit, c1, b1.mem_ready, b1.busy);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        saw_ready = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (b1.mem_ready !== 1'b0 || c1 !== 1'b1) saw_ready = 1'b1;
        end
        checks++;
        if (saw_ready) begin
            errors++; $display("FAIL reset_mid_quiet: got activity after reset required none");
        end
        txn(1'b0, 24'h000100, 32'h0, 4'h0, 1'b0, rd, lat, bok);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL reset_mid_reread: got %h required deadbeef", rd);
        end
    endtask

    task automatic test_latch();
        logic [31:0] rd; int lat; bit bok;
        clear_log();
        txn(1'b0, 24'h000300, 32'hCAFEF00D, 4'hF, 1'b1, rd, lat, bok);
        checks++;
        if (pack_log(8) !== 80'h020003000DF0FECA) begin
            errors++; $display("FAIL latch_mosi: got %h required 020003000DF0FECA", pack_log(8));
        end
        txn(1'b0, 24'h000300, 32'h0, 4'h0, 1'b0, rd, lat, bok);
        checks++;
        if (rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL latch_readback: got %h required cafef00d", rd);
        end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_read();
        test_partial_write();
        test_back_to_back();
        test_reset_mid();
        test_latch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/spiram_master.md
Name: spiram_master

Overview:
Synthesizable SPI master that gives the CPU a word-wide memory port onto an external serial SPI RAM. It uses the RAM's 0x03 read and 0x02 write commands, each followed by a 24-bit address sent MSB first.
- Sits between the native memory bus (valid/ready, 4-bit write strobes) and the spi_* pins.
- In simulation it drives the spiram behavioural model directly.
- Single-lane SPI only, mode 0 (CPOL=0, CPHA=0).

Parameters:
- CLK_DIV, 1, half-period of spi_clk in clk cycles; legal range 1..255.
- CSB_IDLE, 2, minimum spi_csb high time between transactions, in clk cycles; legal range 1..255.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- mem_valid  input  1  request valid; held high with stable fields until mem_ready
- mem_ready  output  1  one-cycle completion pulse
- mem_addr  input  24  byte address; bits [1:0] ignored (word-aligned)
- mem_wdata  input  32  write data, little-endian (byte at addr in [7:0])
- mem_wstrb  input  4  0000 = read; nonzero = write of the selected lanes
- mem_rdata  output  32  read data, valid while mem_ready=1, held until the next read completes
- busy  output  1  high from acceptance until mem_ready
- spi_csb  output  1  chip select, active low
- spi_clk  output  1  SPI clock
- spi_io0  output  1  MOSI
- spi_io1  input  1  MISO

Behaviour:
- Reset (async assert, sync release), all registered:
  - spi_csb=1, spi_clk=0, spi_io0=0.
  - mem_ready=0, busy=0, mem_rdata=0.
  - State IDLE; the idle guard counts as already satisfied.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  - For partial writes, GAP returns to SETUP while strobed lanes remain.
- Acceptance:
  - Occurs in IDLE when mem_valid=1 and spi_csb has been high for at least CSB_IDLE cycles.
  - addr, wdata and wstrb are latched at acceptance; later bus changes are ignored until mem_ready.
- Transaction framing:
  - Read (wstrb=0000): one transaction of 8 bytes: 0x03, A[23:16], A[15:8], A[7:0], then 4 dummy bytes (0x00) on MOSI. The 4 bytes received during the dummy phase are read data.
  - Full write (wstrb=1111): one transaction of 8 bytes: 0x02, address, wdata[7:0], [15:8], [23:16], [31:24].
  - Partial write (any other nonzero wstrb): one 5-byte transaction per set lane, in ascending lane order. Each transaction is 0x02, then address {A[23:2], lane}, then the lane's byte. spi_csb goes high for CSB_IDLE cycles between these transactions.
- SPI timing:
  - Acceptance cycle T: spi_csb falls at T+1 and spi_io0 carries bit 7 of byte 0 from T+1.
  - SETUP lasts CLK_DIV cycles. SHIFT then runs 8*N bits; each bit is CLK_DIV cycles with spi_clk=1 followed by CLK_DIV cycles with spi_clk=0.
  - spi_io1 is sampled on the clk edge where spi_clk rises.
  - spi_io0 changes only on the clk edge where spi_clk falls, or at csb fall for the first bit. Bits go out MSB first.
  - HOLD lasts CLK_DIV cycles with spi_clk=0, then spi_csb rises.
  - spi_csb low time per transaction = (16*N+2)*CLK_DIV cycles.
- mem_ready timing:
  - Pulses on the cycle spi_csb rises after the final transaction, for exactly one cycle. busy drops in the same cycle.
  - With CLK_DIV=1, a read gives mem_ready at T+131.
- Read data: the first received byte goes to mem_rdata[7:0], the fourth to [31:24]. mem_rdata is updated only when a read completes.
- mem_valid low in IDLE: no activity, spi_clk stays 0.
- Reset mid-transaction: spi_csb=1 immediately (asynchronous). The pending request is dropped and mem_ready is not issued. The bus master must re-issue the request.
- Address arithmetic is 24-bit with no carry into other bits. Within a read burst the RAM auto-increments; the master does not re-send the address.

Test Plan:
1. Reset, then 20 idle cycles -> spi_csb=1, spi_clk=0, mem_ready=0, busy=0 throughout.
2. CLK_DIV=1: write 0xDEADBEEF to 0x000100 with wstrb=1111, then read 0x000100.
   - MOSI bytes: 02 00 01 00 EF BE AD DE.
   - The read returns mem_rdata=0xDEADBEEF, with mem_ready exactly 131 cycles after acceptance.
3. Partial write wstrb=0101, wdata=0x11223344, to 0x000200 (pre-filled 0xAAAAAAAA).
   - Exactly two csb-low windows, addresses 0x000200 and 0x000202.
   - Readback = 0xAA22AA44.
4. CLK_DIV=3, CSB_IDLE=4: back-to-back reads with mem_valid held.
   - spi_clk high and low phases are each 3 cycles; csb low time = 390 cycles.
   - csb stays high for at least 4 cycles between the two reads.
5. Assert resetn low during the 3rd address byte of a read.
   - spi_csb=1 in the same cycle; no mem_ready.
   - A subsequent read of a known location returns correct data.
6. Change mem_addr and mem_wdata in the cycle after acceptance -> MOSI stream and result reflect the values latched at acceptance.
